// File: rtl/dif_butterfly.sv
// rtl/dif_butterfly.sv - radix-2 DIF butterfly: yp = xp + xq, yq = round((xp - xq) * W), 4-stage pipeline
module dif_butterfly #(
  parameter int DATA_WIDTH = 27,
  parameter int TWID_WIDTH = 16,
  parameter int SHIFT      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         inv,
  input  logic signed [DATA_WIDTH-1:0] xp_r,
  input  logic signed [DATA_WIDTH-1:0] xp_i,
  input  logic signed [DATA_WIDTH-1:0] xq_r,
  input  logic signed [DATA_WIDTH-1:0] xq_i,
  input  logic signed [TWID_WIDTH-1:0] wn_r,
  input  logic signed [TWID_WIDTH-1:0] wn_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH+1:0] yp_r,
  output logic signed [DATA_WIDTH+1:0] yp_i,
  output logic signed [DATA_WIDTH+1:0] yq_r,
  output logic signed [DATA_WIDTH+1:0] yq_i
);

  localparam int SW = DATA_WIDTH + 1;
  localparam int WW = TWID_WIDTH + 1;
  localparam int PW = DATA_WIDTH + TWID_WIDTH + 2;
  localparam int RW = PW + 1;
  localparam int YW = DATA_WIDTH + 2;
  localparam logic signed [RW-1:0] RND = RW'(1) << (SHIFT - 1);

  logic en;

  // stage valid bits
  logic v1, v2, v3;

  // stage 1: sum, difference, selected twiddle
  logic signed [SW-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic signed [WW-1:0] s1_wr, s1_wi;

  // stage 2: partial products
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
  logic signed [SW-1:0] s2_sr, s2_si;

  // stage 3: complex product
  logic signed [RW-1:0] s3_pr, s3_pi;
  logic signed [SW-1:0] s3_sr, s3_si;

  logic signed [WW-1:0] wi_ext, wi_sel;
  logic signed [PW-1:0] dr_ext, di_ext, wr_ext, wi_pext;
  logic signed [RW-1:0] rnd_r, rnd_i;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // widened before negation so conj of the most negative twiddle does not wrap
  assign wi_ext = WW'(wn_i);
  assign wi_sel = inv ? -wi_ext : wi_ext;

  assign dr_ext  = PW'(s1_dr);
  assign di_ext  = PW'(s1_di);
  assign wr_ext  = PW'(s1_wr);
  assign wi_pext = PW'(s1_wi);

  assign rnd_r = s3_pr + RND;
  assign rnd_i = s3_pi + RND;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      yp_r      <= '0;
      yp_i      <= '0;
      yq_r      <= '0;
      yq_i      <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        yp_r <= YW'(s3_sr);
        yp_i <= YW'(s3_si);
        yq_r <= YW'(rnd_r >>> SHIFT);
        yq_i <= YW'(rnd_i >>> SHIFT);
      end
    end
  end

  // datapath registers need no reset: contents of bubble stages are never observed
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sr <= SW'(xp_r) + SW'(xq_r);
      s1_si <= SW'(xp_i) + SW'(xq_i);
      s1_dr <= SW'(xp_r) - SW'(xq_r);
      s1_di <= SW'(xp_i) - SW'(xq_i);
      s1_wr <= WW'(wn_r);
      s1_wi <= wi_sel;

      s2_rr <= dr_ext * wr_ext;
      s2_ii <= di_ext * wi_pext;
      s2_ri <= dr_ext * wi_pext;
      s2_ir <= di_ext * wr_ext;
      s2_sr <= s1_sr;
      s2_si <= s1_si;

      s3_pr <= RW'(s2_rr) - RW'(s2_ii);
      s3_pi <= RW'(s2_ri) + RW'(s2_ir);
      s3_sr <= s2_sr;
      s3_si <= s2_si;
    end
  end

endmodule

// File: tb/tb_dif_butterfly.sv
// tb/tb_dif_butterfly.sv - self-checking bench for dif_butterfly
module tb_dif_butterfly;

  localparam int DW = 27;
  localparam int TW = 16;
  localparam int SH = 15;
  localparam int YW = DW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 inv;
  logic signed [DW-1:0] xp_r, xp_i, xq_r, xq_i;
  logic signed [TW-1:0] wn_r, wn_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [YW-1:0] yp_r, yp_i, yq_r, yq_i;

  dif_butterfly #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
    .xp_r(xp_r), .xp_i(xp_i), .xq_r(xq_r), .xq_i(xq_i), .wn_r(wn_r), .wn_i(wn_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .yp_r(yp_r), .yp_i(yp_i), .yq_r(yq_r), .yq_i(yq_i)
  );

  typedef struct {
    longint ypr, ypi, yqr, yqi;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   cur;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  longint ov_cnt  = 0;
  bit     acc, stalled, chk_lat;
  longint h_ypr, h_ypi, h_yqr, h_yqi;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sx(input longint v);
    logic signed [YW-1:0] t;
    t = v[YW-1:0];
    return longint'(t);
  endfunction

  // reference: plain integer arithmetic on the currently driven inputs
  task automatic model();
    longint dr, di, wr, wi, pr, pi, rnd;
    dr  = longint'(xp_r) - longint'(xq_r);
    di  = longint'(xp_i) - longint'(xq_i);
    wr  = longint'(wn_r);
    wi  = inv ? -longint'(wn_i) : longint'(wn_i);
    pr  = dr * wr - di * wi;
    pi  = dr * wi + di * wr;
    rnd = longint'(1) << (SH - 1);
    cur.ypr = sx(longint'(xp_r) + longint'(xq_r));
    cur.ypi = sx(longint'(xp_i) + longint'(xq_i));
    cur.yqr = sx((pr + rnd) >>> SH);
    cur.yqi = sx((pi + rnd) >>> SH);
  endtask

  task automatic gen_rand();
    xp_r = DW'($urandom);
    xp_i = DW'($urandom);
    xq_r = DW'($urandom);
    xq_i = DW'($urandom);
    wn_r = TW'($urandom);
    wn_i = TW'($urandom);
    inv  = 1'($urandom);
    model();
  endtask

  task automatic set_beat(input longint apr, api, aqr, aqi, awr, awi, input bit ainv,
                          input longint eypr, eypi, eyqr, eyqi);
    xp_r = DW'(apr);
    xp_i = DW'(api);
    xq_r = DW'(aqr);
    xq_i = DW'(aqi);
    wn_r = TW'(awr);
    wn_i = TW'(awi);
    inv  = ainv;
    cur.ypr = eypr;
    cur.ypi = eypi;
    cur.yqr = eyqr;
    cur.yqi = eyqi;
  endtask

  // one clock: entered and left at a negedge with inputs already driven
  task automatic tick();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid === 1'b1) ov_cnt++;
    stalled = (out_valid === 1'b1) && !out_ready;
    if (stalled) begin
      check("in_ready_stall", longint'(in_ready), 0);
      h_ypr = yp_r; h_ypi = yp_i; h_yqr = yq_r; h_yqi = yq_i;
    end
    if (out_valid === 1'b1 && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", longint'(q.size()), 1);
      end else begin
        e = q.pop_front();
        check("yp_r", yp_r, e.ypr);
        check("yp_i", yp_i, e.ypi);
        check("yq_r", yq_r, e.yqr);
        check("yq_i", yq_i, e.yqi);
        if (chk_lat) check("latency", cyc - e.cyc, 3);
      end
    end
    @(posedge clk);
    cyc++;
    if (acc) begin
      e = cur;
      e.cyc = cyc;
      q.push_back(e);
    end
    #1;
    if (stalled) begin
      check("hold_valid", longint'(out_valid), 1);
      check("hold_yp_r", yp_r, h_ypr);
      check("hold_yp_i", yp_i, h_ypi);
      check("hold_yq_r", yq_r, h_yqr);
      check("hold_yq_i", yq_i, h_yqi);
    end
    @(negedge clk);
  endtask

  task automatic send_one();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    check("accept_timeout", longint'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    check("drain", longint'(q.size()), 0);
  endtask

  task automatic run_stream(input int n, input bit random_mode);
    int sent = 0;
    gen_rand();
    for (int c = 0; c < 40000 && sent < n; c++) begin
      in_valid  = random_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      out_ready = random_mode ? ($urandom_range(0, 4) != 0) : !(c >= 4 && c < 7);
      tick();
      if (acc) begin
        sent++;
        gen_rand();
      end
    end
    check("stream_sent", longint'(sent), longint'(n));
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ov0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0;
    xp_r = '0; xp_i = '0; xq_r = '0; xq_i = '0; wn_r = '0; wn_i = '0;
    chk_lat = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_yp_r", yp_r, 0);
    check("rst_yq_i", yq_i, 0);
    @(negedge clk);

    // unity twiddle
    ov0 = ov_cnt;
    set_beat(100, 0, 40, 0, 32767, 0, 0, 140, 0, 60, 0);
    send_one();
    drain();
    tick();
    tick();
    check("t1_valid_cycles", ov_cnt - ov0, 1);

    // -j twiddle, plain then conjugated, back-to-back
    set_beat(10, 0, 0, 0, 0, -32767, 0, 10, 0, 0, -10);
    send_one();
    set_beat(10, 0, 0, 0, 0, -32767, 1, 10, 0, 0, 10);
    send_one();
    drain();

    // conjugate of -2^15 and extreme difference
    set_beat(0, 0, -67108864, 0, 0, -32768, 1, -67108864, 0, 0, 67108864);
    send_one();
    drain();

    // rounding at exact half values
    set_beat(0, 0, 1, 0, 16384, 0, 0, 1, 0, 0, 0);
    send_one();
    set_beat(0, 0, 1, 0, 16385, 0, 0, 1, 0, -1, 0);
    send_one();
    set_beat(1, 0, 0, 0, 16384, 0, 0, 1, 0, 1, 0);
    send_one();
    drain();

    // streaming with a 3-cycle output stall
    chk_lat = 1'b0;
    run_stream(8, 1'b0);

    // reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      gen_rand();
      send_one();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_yp_r", yp_r, 0);
    check("mid_rst_yq_r", yq_r, 0);
    @(negedge clk);
    tick();
    check("post_rst_out_valid", longint'(out_valid), 0);
    chk_lat = 1'b1;
    set_beat(100, 0, 40, 0, 32767, 0, 0, 140, 0, 60, 0);
    send_one();
    drain();

    // random traffic on both sides
    chk_lat = 1'b0;
    run_stream(10000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
